// File: rtl/instr_encode_loader_if.sv
// Token/write bus bundle for the instruction encoder-loader.
// Carries the symbolic token handshake (in_*) and the instruction-memory write port (im_*).
// The loader drives in_ready and the im_* write signals; the token producer drives the in_* fields.
//
// Ports (signals):
//   in_valid/in_ready      token handshake, transfer when both high
//   in_kind/rs/rt/rd/imm/target  symbolic token fields
//   im_we/im_addr/im_wdata instruction-memory write strobe, word address and data
interface instr_encode_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // Loader side: consumes tokens, produces memory writes.
  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, im_we, im_addr, im_wdata
  );

  // Producer side: drives tokens, observes writes.
  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes symbolic MIPS tokens and writes them sequentially into instruction memory.
// Latency: token accepted at edge N -> im_we/im_addr/im_wdata valid during cycle N+1.
// Backpressure: in_ready low outside LOAD, when full, and in the start cycle.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, finish     one-cycle session control pulses
//   bus (slave)       token handshake in, instruction-memory write port out
//   count             words written this session (0..DEPTH)
//   full, busy, done  count==DEPTH, state==LOAD, state==DONE
//   err_illegal       sticky flag: an illegal kind was consumed
module instr_encode_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  instr_encode_loader_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        in_ready;
  logic        accept;
  logic        legal_d;
  logic [31:0] word_d;

  assign full     = (count_q == DEPTH);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign in_ready = busy & ~full & ~start;
  assign accept   = bus.in_valid & in_ready;

  assign bus.in_ready = in_ready;
  assign bus.im_we    = we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign count        = count_q;
  assign err_illegal  = err_q;

  // Token -> 32-bit MIPS word; fields unused by a format are ignored.
  always_comb begin
    legal_d = 1'b1;
    word_d  = 32'h0;
    case (bus.in_kind)
      4'd0: word_d = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100000}; // ADD
      4'd1: word_d = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100010}; // SUB
      4'd2: word_d = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100100}; // AND
      4'd3: word_d = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100101}; // OR
      4'd4: word_d = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b101010}; // SLT
      4'd5: word_d = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};                 // LW
      4'd6: word_d = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};                 // SW
      4'd7: word_d = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};                 // ADDI
      4'd8: word_d = {6'b000111, bus.in_rs, bus.in_rt, bus.in_imm};                 // BR
      4'd9: word_d = {6'b000010, bus.in_target};                                    // J
      default: legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= 32'h0;
    end else begin
      we_q <= 1'b0;
      if (start) begin
        // Start is honoured in every state and restarts an active session.
        state_q <= LOAD;
        ptr_q   <= BASE;
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (state_q == LOAD) begin
        if (accept) begin
          if (legal_d) begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= word_d;
            ptr_q   <= ptr_q + 1'b1;   // natural wrap modulo DEPTH
            count_q <= count_q + 1'b1;
          end else begin
            err_q <= 1'b1;             // illegal token is consumed, nothing written
          end
        end
        // full and accept are exclusive, so the last write has already issued.
        if (finish || full) begin
          state_q <= DONE;
        end
      end
    end
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Takes symbolic instruction tokens (kind plus register, immediate and target fields) over a valid/ready handshake.
- Encodes each token into the 32-bit MIPS word that the single-cycle control decoder consumes.
- Writes the words sequentially into instruction memory, so it is the encoder and writer on the producer side of the instruction path.
- Used by the bench and boot logic to preload programs before the CPU leaves reset.

Parameters:
- ADDR_W, 6, width of the instruction-memory word address; capacity DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0, word address the first instruction is written to. Addresses wrap modulo DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: clear pointer, count and error, then enter LOAD.
- finish  input  1  one-cycle pulse: end the load session.
- in_valid  input  1  token valid.
- in_ready  output  1  token accepted when in_valid & in_ready.
- in_kind  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 ADDI, 8 BR, 9 J, 10-15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate field.
- in_target  input  26  jump target field.
- im_we  output  1  instruction-memory write strobe.
- im_addr  output  ADDR_W  write address.
- im_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written this session.
- full  output  1  count == DEPTH.
- busy  output  1  state == LOAD.
- done  output  1  state == DONE.
- err_illegal  output  1  sticky: an illegal kind was accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, err_illegal=0.
  - Internal write pointer = BASE_ADDR.
- States: IDLE, LOAD, DONE. busy and done decode state; full decodes count.
- Transitions:
  - IDLE -start-> LOAD.
  - LOAD -finish-> DONE.
  - LOAD -(count reaches DEPTH)-> DONE.
  - DONE -start-> LOAD.
  - start in LOAD restarts the session: pointer=BASE_ADDR, count=0, err cleared, state stays LOAD.
- in_ready = (state==LOAD) & !full & !start, combinational. No token is accepted in the start cycle.
- Encoding (all outputs registered):
  - R kinds 0-4: {6'b000000, rs, rt, rd, 5'b0, funct}. funct is ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I kinds: {op, rs, rt, imm}. op is LW 100011, SW 101011, ADDI 001000, BR 000111.
  - J: {000010, target}.
  - Fields a format does not use are ignored.
- Latency: a legal token accepted at edge N gives im_we=1, im_addr=ptr, im_wdata=word during cycle N+1. ptr and count increment at that same edge N.
- Throughput is one word per cycle. Back-to-back accepts produce consecutive im_we pulses at ptr, ptr+1, ...
- Illegal kind accepted:
  - err_illegal set (sticky until start or reset).
  - No write; ptr and count unchanged.
  - Token is consumed (handshake completes).
- Pointer wraps from DEPTH-1 to 0 when BASE_ADDR != 0. count never exceeds DEPTH.
- Full: once count == DEPTH, in_ready=0 and state moves to DONE at the next edge. The final write still issues.
- Simultaneous accept and finish in the same cycle: the token is written, then state is DONE.
- finish outside LOAD is ignored. start while in_valid is high: the token is not accepted.
- im_we is high for exactly one cycle per legal word and is never high in IDLE after reset.
- Reset asserted mid-session aborts immediately: a pending im_we is dropped and all outputs return to reset values.

Test Plan:
- Reset then start, send ADD rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221820; count=1.
- Back-to-back tokens with no gaps:
  - LW rs=1 rt=5 imm=0x0004 -> 0x8C250004 at addr 0.
  - BR rs=1 rt=2 imm=0xFFFE -> 0x1C22FFFE at addr 1.
  - J target=0x0000010 -> 0x08000010 at addr 2.
  - Expect three consecutive im_we cycles.
- in_kind=4'hF accepted -> err_illegal=1, no im_we, count unchanged. The next legal token is written at the unchanged address. A later start clears err_illegal.
- ADDR_W=2, BASE_ADDR=3, five valid tokens:
  - Writes go to addresses 3, 0, 1, 2.
  - full=1 and in_ready=0 after the fourth accept; the fifth token stalls.
  - done=1.
- Token accepted together with finish -> word written, then done=1 and in_ready=0. A following start -> busy=1, count=0, writes resume at BASE_ADDR.
- rst_n pulled low the cycle after an accept -> im_we is never seen high. Outputs return to reset values immediately, without waiting for a clock edge.
